muldiv_sequencer: RTL and testbench

Multi-cycle multiply/divide unit with its own sequencing FSM that serves MULT, MULTU, DIV and DIVU for the multicycle MIPS core. The main Control FSM pulses `start` with operands taken from the A/B registers. It then holds in a wait state while `busy` is high and resumes on `done`. Results land in architectural HI/LO registers that MFHI/MFLO route into the register-file write-data mux.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/twos_abs.sv | 13 +
 rtl/muldiv_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
// Operation and state encodings are shared by the RTL and any code that drives it.
package muldiv_pkg;

    localparam int MULDIV_W = 32;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        SIGN = 3'd3,
        DONE = 3'd4
    } muldiv_state_t;

endpackage

// File: rtl/twos_abs.sv
// Conditional two's-complement negate: used both to take operand magnitudes
// and to restore signs on the finished product, quotient and remainder.
module twos_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] value_i,
    input  logic         negate_i,
    output logic [W-1:0] result_o
);

    assign result_o = negate_i ? (~value_i + W'(1)) : value_i;

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequenced MULT/MULTU/DIV/DIVU unit: magnitudes in, one shift-add or restoring
// divide step per cycle, sign fix-up at the end, results held in HI/LO.
import muldiv_pkg::*;

module muldiv_sequencer #(
    parameter int WIDTH = MULDIV_W
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] oper_A,
    input  logic [WIDTH-1:0] oper_B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    muldiv_state_t      state_q, state_d;
    muldiv_op_t         op_q, op_d;
    logic [WIDTH-1:0]   magA_q, magA_d;
    logic [WIDTH-1:0]   magB_q, magB_d;
    logic               resSign_q, resSign_d;
    logic               remSign_q, remSign_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               divZero_q, divZero_d;

    logic               inSigned;
    logic               isDivQ;
    logic [WIDTH-1:0]   absA, absB;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quotFix, remFix;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     remShift;
    logic [WIDTH-1:0]   remTrial;
    logic               remGe;

    assign inSigned = (op == MULT) || (op == DIV);
    assign isDivQ   = (op_q == DIV) || (op_q == DIVU);

    twos_abs #(.W(WIDTH)) uAbsA (
        .value_i  (oper_A),
        .negate_i (inSigned & oper_A[WIDTH-1]),
        .result_o (absA)
    );

    twos_abs #(.W(WIDTH)) uAbsB (
        .value_i  (oper_B),
        .negate_i (inSigned & oper_B[WIDTH-1]),
        .result_o (absB)
    );

    twos_abs #(.W(2*WIDTH)) uProdFix (
        .value_i  (acc_q),
        .negate_i (resSign_q),
        .result_o (prodFix)
    );

    twos_abs #(.W(WIDTH)) uQuotFix (
        .value_i  (acc_q[WIDTH-1:0]),
        .negate_i (resSign_q),
        .result_o (quotFix)
    );

    twos_abs #(.W(WIDTH)) uRemFix (
        .value_i  (acc_q[2*WIDTH-1:WIDTH]),
        .negate_i (remSign_q),
        .result_o (remFix)
    );

    // Multiply keeps the carry of the upper-half add; divide feeds the next
    // dividend bit into the partial remainder, shifted out of magA_q.
    assign mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (magB_q[0] ? {1'b0, magA_q} : '0);
    assign remShift = {acc_q[2*WIDTH-1:WIDTH], magA_q[WIDTH-1]};
    assign remGe    = (remShift >= {1'b0, magB_q});
    assign remTrial = remShift[WIDTH-1:0] - magB_q;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= MULT;
            magA_q    <= '0;
            magB_q    <= '0;
            resSign_q <= 1'b0;
            remSign_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            divZero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            magA_q    <= magA_d;
            magB_q    <= magB_d;
            resSign_q <= resSign_d;
            remSign_q <= remSign_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divZero_q <= divZero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        magA_d    = magA_q;
        magB_d    = magB_q;
        resSign_d = resSign_q;
        remSign_d = remSign_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divZero_d = divZero_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = muldiv_op_t'(op);
                    magA_d    = absA;
                    magB_d    = absB;
                    resSign_d = inSigned & (oper_A[WIDTH-1] ^ oper_B[WIDTH-1]);
                    remSign_d = inSigned & oper_A[WIDTH-1];
                    divZero_d = 1'b0;
                    state_d   = PREP;
                end
            end
            PREP: begin
                // A zero divisor skips straight to DONE and leaves HI/LO untouched.
                if (isDivQ && (magB_q == '0)) begin
                    divZero_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                if (isDivQ) begin
                    acc_d  = {(remGe ? remTrial : remShift[WIDTH-1:0]),
                              acc_q[WIDTH-2:0], remGe};
                    magA_d = {magA_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d  = {mulSum, acc_q[WIDTH-1:1]};
                    magB_d = {1'b0, magB_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                if (isDivQ) begin
                    hi_d = remFix;
                    lo_d = quotFix;
                end else begin
                    hi_d = prodFix[2*WIDTH-1:WIDTH];
                    lo_d = prodFix[WIDTH-1:0];
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q == PREP) || (state_q == ITER) || (state_q == SIGN);
    assign done     = (state_q == DONE);
    assign div_zero = divZero_q;
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO/div_zero come from a
// 64-bit arithmetic model and are checked by a monitor whenever done pulses.
module tb_muldiv_sequencer;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        Clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operA;
    logic [31:0] operB;
    logic        busy;
    logic        done;
    logic        divZero;
    logic [31:0] hiOut;
    logic [31:0] loOut;

    int   checks = 0;
    int   fails  = 0;
    exp_t sbQ[$];
    logic [31:0] modelHi = 32'd0;
    logic [31:0] modelLo = 32'd0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .Clk      (Clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .oper_A   (operA),
        .oper_B   (operB),
        .busy     (busy),
        .done     (done),
        .div_zero (divZero),
        .HI       (hiOut),
        .LO       (loOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero
    // and % follows the dividend's sign, matching the MIPS semantics.
    function automatic exp_t refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int ia, ib;
        longint sa, sb, p, q, r;
        longint unsigned up;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        e.hi = modelHi;
        e.lo = modelLo;
        e.dz = 1'b0;
        case (o)
            2'd0: begin
                p = sa * sb;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'd1: begin
                up = {32'd0, a} * {32'd0, b};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            2'd2: begin
                if (b == 32'd0) begin
                    e.dz = 1'b1;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    e.dz = 1'b1;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Issues one op, pushes its expectation, and tracks done latency/busy.
    // glitchAt pulses start during the op; resetAt drops reset after that edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input int glitchAt, input int resetAt);
        exp_t e;
        int   expLat;
        bit   seen;
        bit   busyBad;
        @(negedge Clk);
        e = refModel(o, a, b);
        modelHi = e.hi;
        modelLo = e.lo;
        sbQ.push_back(e);
        expLat = (o[1] && (b == 32'd0)) ? 1 : 34;
        start = 1'b1;
        op    = o;
        operA = a;
        operB = b;
        @(posedge Clk);
        @(negedge Clk);
        start = 1'b0;
        checkOutput("busy_prep", 64'(busy), 64'd1);
        seen    = 1'b0;
        busyBad = 1'b0;
        for (int k = 1; k <= 100 && !seen; k++) begin
            @(posedge Clk);
            if (k == resetAt) begin
                #2 reset = 1'b0;
                #1;
                checkOutput("rst_busy", 64'(busy), 64'd0);
                checkOutput("rst_done", 64'(done), 64'd0);
                checkOutput("rst_div_zero", 64'(divZero), 64'd0);
                checkOutput("rst_HI", 64'(hiOut), 64'd0);
                checkOutput("rst_LO", 64'(loOut), 64'd0);
                sbQ.delete();
                modelHi = 32'd0;
                modelLo = 32'd0;
                repeat (2) @(negedge Clk);
                reset = 1'b1;
                return;
            end
            @(negedge Clk);
            start = (k == glitchAt);
            if (k == glitchAt) begin
                op    = 2'($urandom_range(0, 3));
                operA = $urandom;
                operB = $urandom;
            end
            if (done) begin
                seen = 1'b1;
                checkOutput("done_latency", 64'(k), 64'(expLat));
            end else if (!busy) begin
                busyBad = 1'b1;
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            fails++;
            $display("[TB] FAIL done_timeout: got no done, expected done within 100 cycles at %0t", $time);
        end else begin
            checkOutput("busy_during_op", 64'(busyBad), 64'd0);
            @(posedge Clk);
            @(negedge Clk);
            checkOutput("done_one_cycle", 64'(done), 64'd0);
            checkOutput("busy_idle", 64'(busy), 64'd0);
        end
    endtask

    // Monitor: every done pulse retires exactly one scoreboard entry.
    always @(negedge Clk) begin
        exp_t e;
        if (reset && done) begin
            if (sbQ.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_done: got done, expected none at %0t", $time);
            end else begin
                e = sbQ.pop_front();
                checkOutput("HI", 64'(hiOut), 64'(e.hi));
                checkOutput("LO", 64'(loOut), 64'(e.lo));
                checkOutput("div_zero", 64'(divZero), 64'(e.dz));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b;
        int          r;
        reset = 1'b0;
        start = 1'b0;
        op    = 2'd0;
        operA = 32'd0;
        operB = 32'd0;
        #3;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_div_zero", 64'(divZero), 64'd0);
        checkOutput("reset_HI", 64'(hiOut), 64'd0);
        checkOutput("reset_LO", 64'(loOut), 64'd0);
        repeat (2) @(negedge Clk);
        reset = 1'b1;

        applyStimulus(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        applyStimulus(2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 0, 0);
        applyStimulus(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
        applyStimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        applyStimulus(2'd3, 32'h0000_0007, 32'h0000_0002, 0, 0);
        applyStimulus(2'd3, 32'h0000_0005, 32'h0000_0000, 0, 0);
        applyStimulus(2'd2, 32'h0000_0009, 32'h0000_0000, 0, 0);

        applyStimulus(2'd0, 32'd12345, 32'hFFFF_FD5A, 5, 0);
        applyStimulus(2'd1, 32'hDEAD_BEEF, 32'h0000_1234, 0, 10);
        applyStimulus(2'd1, 32'd6, 32'd7, 0, 0);

        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            r = $urandom_range(0, 5);
            if (r == 0)      b = 32'd0;
            else if (r == 1) b = 32'($urandom_range(1, 16));
            else             b = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            applyStimulus(o, a, b, 0, 0);
        end

        repeat (3) @(negedge Clk);
        checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
